// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
//   Single-master I2C controller. Runs one complete one-byte transaction per
//   accepted command: START, {addr, rw}, address ACK, one data byte (written or
//   read), data ACK / master NACK, STOP. SCL is push-pull; SDA is open drain.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | bus released, cmd_ready high
//   START | scl high; sda released for q0-q1, pulled low for q2-q3
//   ADDR  | shift out {addr, rw}, MSB first
//   AACK  | release sda, sample slave ACK for the address
//   WRITE | shift out the write byte, MSB first
//   WACK  | release sda, sample slave ACK for the data byte
//   READ  | release sda, shift in 8 bits, MSB first
//   MNACK | release sda for one bit to end the read
//   STOP  | sda low while scl rises, then sda released with scl high
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_addr, cmd_rw, cmd_wdata 7-bit address, 1 = read, write byte
//   rd_data, rd_valid           read byte and its one-cycle valid pulse
//   done, nack, busy            completion pulse, slave NACK flag, activity
//   scl, sda                    I2C bus (sda driven low or released only)

module i2c_master_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       nack,
   output logic       busy,
   output logic       scl,
   inout  wire        sda
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_MNACK, S_STOP
   } state_t;

   localparam int            QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

   state_t        state, state_nx;
   logic [QW-1:0] qcnt;
   logic [1:0]    qidx;
   logic [2:0]    bitcnt;
   logic [6:0]    addr_q;
   logic          rw_q;
   logic [7:0]    wdata_q;
   logic [7:0]    rx_sh;
   logic [7:0]    addr_byte;
   logic          sda_low;
   logic          sda_bit;
   logic          accept;
   logic          q_last;
   logic          bit_end;
   logic          sample;

   assign accept    = (state == S_IDLE) && cmd_valid;
   assign q_last    = (qcnt == QMAX);
   assign bit_end   = q_last && (qidx == 2'd3);
   assign sample    = q_last && (qidx == 2'd2);
   assign addr_byte = {addr_q, rw_q};

   assign sda = sda_low ? 1'b0 : 1'bz;

   // Anything other than a solid 0 (released, x, z) reads as 1.
   always_comb begin
      if (sda == 1'b0) sda_bit = 1'b0;
      else             sda_bit = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nx = S_START;
         S_START: if (bit_end) state_nx = S_ADDR;
         S_ADDR:  if (bit_end && bitcnt == 3'd0) state_nx = S_AACK;
         S_AACK:  if (bit_end) state_nx = nack ? S_STOP : (rw_q ? S_READ : S_WRITE);
         S_WRITE: if (bit_end && bitcnt == 3'd0) state_nx = S_WACK;
         S_WACK:  if (bit_end) state_nx = S_STOP;
         S_READ:  if (bit_end && bitcnt == 3'd0) state_nx = S_MNACK;
         S_MNACK: if (bit_end) state_nx = S_STOP;
         S_STOP:  if (bit_end) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      scl       = 1'b1;
      sda_low   = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_START: sda_low = qidx[1];
         S_ADDR: begin
            scl     = qidx[1];
            sda_low = ~addr_byte[bitcnt];
         end
         S_WRITE: begin
            scl     = qidx[1];
            sda_low = ~wdata_q[bitcnt];
         end
         S_AACK, S_WACK, S_READ, S_MNACK: scl = qidx[1];
         S_STOP: begin
            scl     = qidx[1];
            sda_low = (qidx != 2'd3);
         end
         default: ;
      endcase
   end

   // The accept clock doubles as the first clock of START: its bus levels
   // match idle, and counting it keeps accept-to-done at 20 (or 11) bit periods.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         qcnt <= '0;
         qidx <= '0;
      end else if (state == S_IDLE && !cmd_valid) begin
         qcnt <= '0;
         qidx <= '0;
      end else if (q_last) begin
         qcnt <= '0;
         qidx <= qidx + 2'd1;
      end else begin
         qcnt <= qcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt <= 3'd0;
      end else if (bit_end) begin
         case (state)
            S_START, S_AACK:        bitcnt <= 3'd7;
            S_ADDR, S_WRITE, S_READ: if (bitcnt != 3'd0) bitcnt <= bitcnt - 3'd1;
            default:                bitcnt <= 3'd0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         rw_q     <= 1'b0;
         wdata_q  <= '0;
         rx_sh    <= '0;
         rd_data  <= '0;
         nack     <= 1'b0;
         done     <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         if (accept) begin
            addr_q  <= cmd_addr;
            rw_q    <= cmd_rw;
            wdata_q <= cmd_wdata;
            nack    <= 1'b0;
         end
         if (sample) begin
            case (state)
               S_AACK, S_WACK: if (sda_bit) nack <= 1'b1;
               S_READ:         rx_sh <= {rx_sh[6:0], sda_bit};
               default: ;
            endcase
         end
         if (bit_end && state == S_READ && bitcnt == 3'd0) rd_data <= rx_sh;
         if (bit_end && state == S_STOP) begin
            done     <= 1'b1;
            rd_valid <= rw_q && !nack;
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Testbench for i2c_master_ctrl: behavioural slave at 7'h64, bus monitor,
// and a scoreboard of expected transaction results checked on done.

module tb_i2c_master_ctrl;

   localparam int D        = 4;
   localparam int LAT_FULL = 80 * D;
   localparam int LAT_NACK = 44 * D;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_rw    = 1'b0;
   logic [6:0] cmd_addr  = '0;
   logic [7:0] cmd_wdata = '0;
   logic       cmd_ready, rd_valid, done, nack, busy, scl;
   logic [7:0] rd_data;
   wire        sda;
   logic       slave_low = 1'b0;

   assign sda = slave_low ? 1'b0 : 1'bz;
   pullup (sda);
   wire sda_v = (sda === 1'b0) ? 1'b0 : 1'b1;

   i2c_master_ctrl #(.CLK_DIV(D)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .nack(nack),
      .busy(busy), .scl(scl), .sda(sda)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bits;
      int          n;
      logic        nack;
      logic        rdv;
      logic [7:0]  rd;
      int          lat;
   } item_t;

   item_t exp_q[$];
   int    acc_q[$];
   item_t cur;
   int    acc_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic        slave_en = 1'b1;
   logic        ack_data = 1'b1;
   logic [7:0]  rd_byte  = 8'h00;
   int          sb       = 0;
   logic [31:0] sh       = '0;
   logic        s_rw     = 1'b0;
   logic        s_sel    = 1'b0;

   logic        p_scl = 1'b1, p_sda = 1'b1;
   logic [31:0] mon_bits = '0, frame_bits = '0;
   int          mon_n = 0, frame_n = 0, frame_starts = 0;
   logic        stop_flag = 1'b0;
   int          done_cnt = 0;
   int          last_done_cyc = -1, last_acc_cyc = -2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] frame(input logic [6:0] a, input logic rw, input logic aack,
                                         input logic [7:0] d, input logic dack, input logic full);
      if (!full) return {22'b0, a, rw, aack, 1'b0};
      return {13'b0, a, rw, aack, d, dack, 1'b0};
   endfunction

   always @(posedge clk) cyc++;

   // Monitor, slave and scoreboard checker, all sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         mon_bits = '0; mon_n = 0; sb = 0; sh = '0; s_sel = 1'b0; slave_low = 1'b0;
         acc_q.delete(); frame_starts = 0; stop_flag = 1'b0;
      end else begin
         if (p_scl && scl && p_sda && !sda_v) begin
            frame_starts++; mon_bits = '0; mon_n = 0; sb = 0; sh = '0; s_sel = 1'b0;
         end
         if (p_scl && scl && !p_sda && sda_v) begin
            stop_flag = 1'b1; frame_bits = mon_bits; frame_n = mon_n;
         end
         if (!p_scl && scl) begin
            mon_bits = {mon_bits[30:0], sda_v}; mon_n++;
            sh = {sh[30:0], sda_v}; sb++;
         end
         if (p_scl && !scl) begin
            slave_low = 1'b0;
            if (sb == 8) begin
               s_rw      = sh[0];
               s_sel     = slave_en && (sh[7:1] == 7'h64);
               slave_low = s_sel;
            end else if (s_sel && s_rw && sb >= 9 && sb <= 16) begin
               slave_low = !rd_byte[16 - sb];
            end else if (s_sel && !s_rw && sb == 17) begin
               slave_low = ack_data;
            end
         end
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               cur   = exp_q.pop_front();
               acc_t = acc_q.pop_front();
               chk("latency", cyc - acc_t, cur.lat);
               chk("nack", nack, cur.nack);
               chk("rd_valid", rd_valid, cur.rdv);
               if (cur.rdv) chk("rd_data", rd_data, cur.rd);
               chk("bus_bits", frame_bits, cur.bits);
               chk("bus_nbits", frame_n, cur.n);
               chk("stop_seen", stop_flag, 1);
               chk("start_count", frame_starts, 1);
            end
            stop_flag    = 1'b0;
            frame_starts = 0;
         end
         if (rd_valid && !done) chk("rd_valid_without_done", 1, 0);
         if (cmd_valid && cmd_ready) begin
            acc_q.push_back(cyc);
            last_acc_cyc = cyc;
         end
      end
      p_scl = scl;
      p_sda = sda_v;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [6:0] a, input logic rw, input logic [7:0] d);
      item_t e;
      logic  aok;
      aok    = slave_en && (a == 7'h64);
      e.nack = !aok || (!rw && !ack_data);
      if (!aok) begin
         e.bits = frame(a, rw, 1'b1, 8'h00, 1'b0, 1'b0);
         e.n    = 10;
         e.lat  = LAT_NACK;
         e.rdv  = 1'b0;
         e.rd   = 8'h00;
      end else begin
         e.bits = frame(a, rw, 1'b0, rw ? rd_byte : d, rw ? 1'b1 : !ack_data, 1'b1);
         e.n    = 19;
         e.lat  = LAT_FULL;
         e.rdv  = rw;
         e.rd   = rd_byte;
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      int n0 = done_cnt;
      int k  = 0;
      while (done_cnt == n0 && k < 2000) begin
         step();
         k++;
      end
      if (done_cnt == n0) chk("done_timeout", 0, 1);
   endtask

   task automatic send(input logic [6:0] a, input logic rw, input logic [7:0] d);
      push_exp(a, rw, d);
      cmd_addr  = a;
      cmd_rw    = rw;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      wait_done();
   endtask

   initial begin
      int k;
      int n0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_scl", scl, 1);
      chk("reset_sda", sda_v, 1);
      chk("reset_done", done, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_nack", nack, 0);
      chk("reset_rd_data", rd_data, 0);

      // 1: write with ACKs
      send(7'h64, 1'b0, 8'hA5);
      // 2: read one byte
      rd_byte = 8'hAA;
      send(7'h64, 1'b1, 8'h00);
      // 3: absent slave, address NACK on a read
      send(7'h10, 1'b1, 8'h00);
      // 4: data NACK
      ack_data = 1'b0;
      send(7'h64, 1'b0, 8'h3C);
      ack_data = 1'b1;

      // 5: reset in the middle of WRITE bit 3
      cmd_addr = 7'h64; cmd_rw = 1'b0; cmd_wdata = 8'hF0; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      k = 0;
      while (!(frame_starts == 1 && mon_n >= 13) && k < 1000) begin step(); k++; end
      if (mon_n < 13) chk("reach_write_bit4", mon_n, 13);
      k = 0;
      while (scl !== 1'b0 && k < 100) begin step(); k++; end
      step(); step();
      n0  = done_cnt;
      rst = 1'b1;
      #1;
      chk("abort_scl", scl, 1);
      chk("abort_sda", sda_v, 1);
      chk("abort_busy", busy, 0);
      chk("abort_rd_data", rd_data, 0);
      repeat (3) step();
      rst = 1'b0;
      repeat (16 * D) step();
      chk("abort_no_done", done_cnt, n0);
      chk("abort_cmd_ready", cmd_ready, 1);
      send(7'h64, 1'b0, 8'h55);

      // 6: back-to-back with cmd_valid held, noise on inputs while busy
      rd_byte = 8'h5A;
      push_exp(7'h64, 1'b0, 8'h11);
      push_exp(7'h64, 1'b1, 8'h00);
      cmd_addr = 7'h64; cmd_rw = 1'b0; cmd_wdata = 8'h11; cmd_valid = 1'b1;
      step();
      cmd_addr = 7'h64; cmd_rw = 1'b1; cmd_wdata = 8'hEE;
      wait_done();
      chk("b2b_accept_in_done_cycle", last_acc_cyc, last_done_cyc);
      for (int i = 0; i < 60; i++) begin
         cmd_valid = i[0];
         cmd_addr  = 7'h10;
         cmd_rw    = 1'b0;
         cmd_wdata = 8'hFF;
         step();
      end
      cmd_valid = 1'b0;
      wait_done();
      repeat (8) step();
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("final_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
